// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding,
// default operand width and iteration counter width.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } div_state_t;

    localparam int DIV_W     = 32;
    localparam int DIV_CNT_W = $clog2(DIV_W);

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quo} left by one, try to
// subtract the divisor, keep the difference and set the quotient bit when
// it does not go negative.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic        [WIDTH+1:0] shifted;
    logic signed [WIDTH+1:0] trial;

    // Shift-and-subtract; the extra top bit of trial acts as the sign.
    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        trial   = $signed(shifted - {2'b00, divisor});
        if (!trial[WIDTH+1]) begin
            rem_next = trial[WIDTH:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = shifted[WIDTH:0];
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Multicycle signed restoring divider feeding the Lo/Hi registers.
// Optional macro SEQ_DIV_UNSIGNED_EN adds the is_unsigned input (divu).
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef SEQ_DIV_UNSIGNED_EN
    input  logic             is_unsigned,
`endif
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CNT_W = $clog2(WIDTH);

    div_state_t       state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvsr;
    logic             q_neg;
    logic             r_neg;
    logic [WIDTH:0]   rem_step;
    logic [WIDTH-1:0] quo_step;
    logic             div_unsigned;
    logic             accept;
    logic             zero_req;
    logic             last_iter;

`ifdef SEQ_DIV_UNSIGNED_EN
    assign div_unsigned = is_unsigned;
`else
    assign div_unsigned = 1'b0;
`endif

    assign accept    = (state == IDLE) && start && (divisor != '0);
    assign zero_req  = (state == IDLE) && start && (divisor == '0);
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

    // Magnitude of an operand; -2^(WIDTH-1) maps onto itself read as unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                   input logic             uns);
        return (uns || !x[WIDTH-1]) ? x : (~x + 1'b1);
    endfunction

    // Two's-complement negate when the latched sign says so.
    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] x,
                                                    input logic             neg);
        return neg ? (~x + 1'b1) : x;
    endfunction

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (dvsr),
        .rem_next (rem_step),
        .quo_next (quo_step)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic: zero divisors are answered without leaving IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)    state_next = CALC;
            CALC:    if (last_iter) state_next = FIX;
            FIX:                    state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Output decode: busy covers the iterations and the sign fix cycle.
    always_comb begin
        busy = (state == CALC) || (state == FIX);
    end

    // Datapath: operand capture, iteration, sign fixup and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            rem       <= '0;
            quo       <= '0;
            dvsr      <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        quo   <= magnitude(dividend, div_unsigned);
                        dvsr  <= magnitude(divisor, div_unsigned);
                        rem   <= '0;
                        cnt   <= '0;
                        q_neg <= !div_unsigned && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        r_neg <= !div_unsigned && dividend[WIDTH-1];
                    end else if (zero_req) begin
                        done     <= 1'b1;
                        div_zero <= 1'b1;
                    end
                end
                CALC: begin
                    rem <= rem_step;
                    quo <= quo_step;
                    cnt <= cnt + CNT_W'(1);
                end
                FIX: begin
                    quotient  <= apply_sign(quo, q_neg);
                    remainder <= apply_sign(rem[WIDTH-1:0], r_neg);
                    done      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: a cycle-level reference model built
// on plain integer division, checked every cycle, plus literal expectations.
`timescale 1ns/1ps
module tb_seq_divider;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        is_unsigned;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int checks   = 0;
    int failures = 0;

    seq_divider #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
`ifdef SEQ_DIV_UNSIGNED_EN
        .is_unsigned (is_unsigned),
`endif
        .busy        (busy),
        .done        (done),
        .div_zero    (div_zero),
        .quotient    (quotient),
        .remainder   (remainder)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result straight from the language's truncating division.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    input logic u, output logic [31:0] q,
                                    output logic [31:0] r);
        longint sa, sb, lq, lr;
        if (u) begin
            sa = longint'({32'b0, a});
            sb = longint'({32'b0, b});
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end
        lq = sa / sb;
        lr = sa % sb;
        q  = lq[31:0];
        r  = lr[31:0];
    endfunction

    // Reference timeline: a divide occupies 33 edges after its start edge.
    int          m_left;
    logic [31:0] m_q, m_r, p_q, p_r;
    logic        m_done, m_dz;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_left = 0; m_q = 0; m_r = 0; m_done = 0; m_dz = 0;
        end else begin
            m_done = 0;
            m_dz   = 0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_q = p_q; m_r = p_r; m_done = 1;
                end
            end else if (start) begin
                if (divisor == 32'd0) begin
                    m_done = 1; m_dz = 1;
                end else begin
`ifdef SEQ_DIV_UNSIGNED_EN
                    ref_div(dividend, divisor, is_unsigned, p_q, p_r);
`else
                    ref_div(dividend, divisor, 1'b0, p_q, p_r);
`endif
                    m_left = 33;
                end
            end
        end
    end

    // Every-cycle comparison against the reference, away from the clock edge.
    always @(negedge clk) begin
        chk("busy",      32'(busy),     32'(m_left > 0));
        chk("done",      32'(done),     32'(m_done));
        chk("div_zero",  32'(div_zero), 32'(m_dz));
        chk("quotient",  quotient,      m_q);
        chk("remainder", remainder,     m_r);
    end

    // Issue one divide; optionally re-pulse start inside CALC. Returns the
    // number of edges from the start edge to the done cycle.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                           input logic u, input int inj_at, output int lat);
        int n;
        @(negedge clk);
        dividend    = a;
        divisor     = b;
        is_unsigned = u;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!done && n < 40) begin
            if (n == inj_at) begin
                start    = 1'b1;
                dividend = 32'd7;
                divisor  = 32'd2;
            end
            @(negedge clk);
            start = 1'b0;
            n++;
        end
        if (!done) chk("done_timeout", 32'(n), 32'd34);
        lat = n - 1;
    endtask

    int lat;
    int seen;

    initial begin
        reset = 1'b1; start = 1'b0; dividend = 0; divisor = 0; is_unsigned = 1'b0;
        #3;
        chk("rst_quotient",  quotient,      32'd0);
        chk("rst_remainder", remainder,     32'd0);
        chk("rst_busy",      32'(busy),     32'd0);
        chk("rst_done",      32'(done),     32'd0);
        @(negedge clk); #2 reset = 1'b0;

        run_div(32'd100, 32'd7, 1'b0, 0, lat);
        chk("q_100_7", quotient, 32'd14);
        chk("r_100_7", remainder, 32'd2);
        chk("lat_100_7", 32'(lat), 32'd33);

        run_div(-32'sd100, 32'd7, 1'b0, 0, lat);
        chk("q_m100_7", quotient, 32'hFFFFFFF2);
        chk("r_m100_7", remainder, 32'hFFFFFFFE);

        run_div(32'd100, -32'sd7, 1'b0, 0, lat);
        chk("q_100_m7", quotient, 32'hFFFFFFF2);
        chk("r_100_m7", remainder, 32'd2);

        run_div(32'h12345678, 32'd0, 1'b0, 0, lat);
        chk("dz_latency", 32'(lat), 32'd0);
        chk("dz_flag", 32'(div_zero), 32'd1);
        chk("dz_busy", 32'(busy), 32'd0);
        chk("dz_q_kept", quotient, 32'hFFFFFFF2);
        chk("dz_r_kept", remainder, 32'd2);

        run_div(32'h80000000, 32'hFFFFFFFF, 1'b0, 0, lat);
        chk("q_ovf", quotient, 32'h80000000);
        chk("r_ovf", remainder, 32'd0);

        run_div(32'd5, 32'd9, 1'b0, 0, lat);
        chk("q_5_9", quotient, 32'd0);
        chk("r_5_9", remainder, 32'd5);

        run_div(32'd1000, 32'd3, 1'b0, 11, lat);
        chk("q_ignore_start", quotient, 32'd333);
        chk("r_ignore_start", remainder, 32'd1);
        chk("lat_ignore_start", 32'(lat), 32'd33);

        // Abort a divide with reset partway through CALC.
        @(negedge clk);
        dividend = 32'd999; divisor = 32'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_quotient",  quotient,      32'd0);
        chk("abort_remainder", remainder,     32'd0);
        chk("abort_busy",      32'(busy),     32'd0);
        @(negedge clk); #2 reset = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("abort_no_done", 32'(seen), 32'd0);

        run_div(32'd100, 32'd7, 1'b0, 0, lat);
        chk("q_after_abort", quotient, 32'd14);
        chk("r_after_abort", remainder, 32'd2);
        chk("lat_after_abort", 32'(lat), 32'd33);

`ifdef SEQ_DIV_UNSIGNED_EN
        run_div(32'hFFFFFFFE, 32'd2, 1'b1, 0, lat);
        chk("q_divu", quotient, 32'h7FFFFFFF);
        chk("r_divu", remainder, 32'd0);
        chk("lat_divu", 32'(lat), 32'd33);
`endif

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
# seq_divider

Multicycle signed 32-bit restoring divider and the responder to the control unit's divide-start request. The control unit asserts `start` from its DIV state, waits for `done`, then routes `quotient` into Lo and `remainder` into Hi through the Lo/Hi source muxes. Divide-by-zero is flagged on `div_zero` so the control unit can take its exception path.

## Interface
- `WIDTH`, default 32: operand and result width.
- `clk`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-high reset.
- `start`  in  1: request a divide; sampled only in IDLE.
- `dividend`  in  WIDTH: two's-complement dividend (A register).
- `divisor`  in  WIDTH: two's-complement divisor (B register).
- `busy`  out  1: high while CALC or FIX.
- `done`  out  1: one-cycle pulse when results are valid or the operation is rejected.
- `div_zero`  out  1: one-cycle pulse, coincident with `done`, when the divisor is 0.
- `quotient`  out  WIDTH: registered quotient, feeds Lo.
- `remainder`  out  WIDTH: registered remainder, feeds Hi.
- `is_unsigned`  in  1: present only with SEQ_DIV_UNSIGNED_EN.

## Operation
- States:
  - IDLE: waits for `start`.
  - CALC: runs WIDTH iterations, counted 0..WIDTH-1.
  - FIX: applies sign correction and writes outputs.
- IDLE with `start`=1 and `divisor`≠0:
  - latch |dividend| into the shift register and |divisor| into the divisor register;
  - latch the result signs: quotient negative iff operand signs differ; remainder sign follows the dividend;
  - clear the partial remainder and counter; go to CALC.
- IDLE with `start`=1 and `divisor`=0:
  - pulse `done` and `div_zero`;
  - leave `quotient`/`remainder` unchanged; stay in IDLE.
- CALC, each cycle:
  - shift {rem, quo} left by 1; trial = rem − divisor;
  - if trial ≥ 0, rem ← trial and quo LSB ← 1; otherwise quo LSB ← 0;
  - at counter = WIDTH-1, go to FIX.
- FIX:
  - negate magnitudes as dictated by the latched signs;
  - write `quotient`/`remainder`; pulse `done`; return to IDLE.
- Arithmetic uses a WIDTH+1-bit internal remainder. Magnitude of −2^(WIDTH-1) is 2^(WIDTH-1), held unsigned.
- Overflow case (−2^(WIDTH-1) / −1): quotient = 0x80000000 (wraps), remainder = 0. There is no overflow flag.
- `start` while `busy` is ignored; operand changes during CALC have no effect.
- `quotient`/`remainder` hold their value until the next FIX, so Lo/Hi may be written any cycle after `done`.

## Timing
- Reset values, applied immediately and asynchronously: state IDLE, `busy`=0, `done`=0, `div_zero`=0, `quotient`=0, `remainder`=0, internal registers 0.
- Let E0 be the edge that samples `start`:
  - `busy` is high from E0 through E(WIDTH+1);
  - results are registered at E(WIDTH+1), and `done` is high for exactly the cycle after E(WIDTH+1);
  - latency is 33 cycles at WIDTH=32.
- Zero divisor: `done`/`div_zero` are high for the single cycle after E0; `busy` stays 0.
- A new `start` is accepted in the cycle `done` is high, because the state is already IDLE. Back-to-back divides are therefore WIDTH+1 cycles apart.
- Reset mid-operation aborts with no `done` pulse; the next `start` behaves normally.

## Configuration
- SEQ_DIV_UNSIGNED_EN:
  - defined: adds the `is_unsigned` input, sampled at E0. When 1, operands are treated as unsigned magnitudes and no sign fixup is applied (divu).
  - undefined: the port is absent and all divides are signed.
- Latency is identical in both builds.

## Structure
- Shared package `div_pkg`:
  - state enum (IDLE, CALC, FIX);
  - `DIV_W` = 32;
  - counter width `$clog2(DIV_W)`.
- One combinational sub-module, `div_step`: given rem, quo and divisor, it returns the next rem and quo for one restoring iteration. `seq_divider` owns the FSM, counter, sign latches and output registers.

## Test plan
- 100 / 7 → `quotient`=14, `remainder`=2, `done` one cycle, 33 cycles after the start edge.
- −100 / 7 → `quotient`=0xFFFFFFF2, `remainder`=0xFFFFFFFE; 100 / −7 → 0xFFFFFFF2, 2.
- 0x12345678 / 0 → `done`=`div_zero`=1 the cycle after E0, `busy` never high, outputs keep the previous result.
- 0x80000000 / 0xFFFFFFFF → `quotient`=0x80000000, `remainder`=0; 5 / 9 → 0, 5.
- `start` pulsed again at iteration 10 with different operands → ignored, first result correct. Then `reset` at iteration 10 of a new divide → all outputs 0 at once, no `done`; a following 100 / 7 yields 14, 2.
- With SEQ_DIV_UNSIGNED_EN and `is_unsigned`=1: 0xFFFFFFFE / 2 → `quotient`=0x7FFFFFFF, `remainder`=0.
